// File: rtl/stream_pkg.sv
// Shared helpers for parameterizing narrow/wide stream blocks.
package stream_pkg;

  // Narrow beat width used when a block is left at its default type.
  localparam int DEFAULT_CW = 8;

  // The counter holds every value from 0 (empty) up to ratio, inclusive.
  function automatic int chunk_cnt_w(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  // Width of a wide beat built from ratio narrow chunks of cw bits.
  function automatic int wide_w(input int ratio, input int cw);
    return ratio * cw;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Splits each wide upstream beat into RATIO narrow downstream beats,
// least-significant chunk first. One wide word of storage; a new word
// loads on the same edge that the last chunk leaves, so there is no bubble.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter type T     = logic [DEFAULT_CW-1:0],
  parameter int  RATIO = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  // wide input stream
  input  logic [RATIO*$bits(T)-1:0] receiver_data,
  input  logic                      receiver_valid,
  output logic                      receiver_ready,
  // narrow output stream
  output T                          sender_data,
  output logic                      sender_valid,
  input  logic                      sender_ready
);

  localparam int CW     = $bits(T);
  localparam int WIDE_W = wide_w(RATIO, CW);
  localparam int CNT_W  = chunk_cnt_w(RATIO);

  // A zero ratio would describe a block with no output beats at all.
  if (RATIO < 1) begin : g_ratio_check
    $fatal(1, "stream_downsizer: RATIO must be >= 1");
  end

  logic [WIDE_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              loaded;
  logic              last_chunk;
  logic              rx_fire;
  logic              tx_fire;

  assign loaded     = (cnt_reg != '0);
  assign last_chunk = (cnt_reg == CNT_W'(1));

  // Accept a new word when empty, or when the final chunk is leaving now.
  // Gated by reset so nothing is taken while the block is being cleared.
  assign receiver_ready = !reset && (!loaded || (last_chunk && sender_ready));

  // Output comes straight from registers; valid never looks at sender_ready.
  assign sender_valid = loaded;
  assign sender_data  = T'(shreg_reg[CW-1:0]);

  assign rx_fire = receiver_valid && receiver_ready;
  assign tx_fire = sender_valid && sender_ready;

  // Load on receive (wins over shift), otherwise shift one chunk out per send.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (rx_fire) begin
      shreg_reg <= receiver_data;
      cnt_reg   <= CNT_W'(RATIO);
    end else if (tx_fire) begin
      shreg_reg <= shreg_reg >> CW;
      cnt_reg   <= cnt_reg - CNT_W'(1);
    end
  end

  // The counter must never be decremented from zero.
  a_no_underflow : assert property (@(posedge clock) disable iff (reset) tx_fire |-> loaded);

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: RATIO=4 byte instance plus a
// RATIO=1 16-bit instance for the register-slice corner case.
module tb_stream_downsizer;

  logic clock = 1'b0;
  logic reset;

  logic [31:0] a_receiver_data;
  logic        a_receiver_valid;
  logic        a_receiver_ready;
  logic [7:0]  a_sender_data;
  logic        a_sender_valid;
  logic        a_sender_ready;

  logic [15:0] b_receiver_data;
  logic        b_receiver_valid;
  logic        b_receiver_ready;
  logic [15:0] b_sender_data;
  logic        b_sender_valid;
  logic        b_sender_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  stream_downsizer #(.T(logic [7:0]), .RATIO(4)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .receiver_data  (a_receiver_data),
    .receiver_valid (a_receiver_valid),
    .receiver_ready (a_receiver_ready),
    .sender_data    (a_sender_data),
    .sender_valid   (a_sender_valid),
    .sender_ready   (a_sender_ready)
  );

  stream_downsizer #(.T(logic [15:0]), .RATIO(1)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .receiver_data  (b_receiver_data),
    .receiver_valid (b_receiver_valid),
    .receiver_ready (b_receiver_ready),
    .sender_data    (b_sender_data),
    .sender_valid   (b_sender_valid),
    .sender_ready   (b_sender_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream nwords wide words (w0 then w1) through dut_a; inputs driven on the
  // falling edge, outputs sampled 1 time unit later. Expected beats come from
  // the words' byte lanes, lowest first.
  task automatic run_case(input string name, input int nwords, input logic [31:0] w0,
                          input logic [31:0] w1, input bit rand_ready, input int max_cycles);
    logic [7:0] exp_q[$];
    int         words_sent = 0;
    int         beats      = 0;
    int         first_cyc  = -1;
    int         last_cyc   = -1;
    int         cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       exp_ready;
    logic [31:0] w;
    for (cyc = 0; cyc < max_cycles &&
         (words_sent < nwords || exp_q.size() > 0 || a_sender_valid); cyc++) begin
      @(negedge clock);
      a_receiver_valid = (words_sent < nwords);
      a_receiver_data  = (words_sent == 0) ? w0 : w1;
      a_sender_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && a_sender_ready);
      check_eq({name, " rx_ready"}, 32'(a_receiver_ready), 32'(exp_ready));
      if (prev_stall) begin
        check_eq({name, " hold valid"}, 32'(a_sender_valid), 32'd1);
        check_eq({name, " hold data"}, 32'(a_sender_data), 32'(prev_data));
      end
      if (a_sender_valid && a_sender_ready) begin
        if (exp_q.size() == 0) begin
          check_eq({name, " unexpected beat"}, 32'(a_sender_data), 32'hFFFF_FFFF);
        end else begin
          check_eq({name, " beat data"}, 32'(a_sender_data), 32'(exp_q.pop_front()));
        end
        $display("[TB] %s: beat %0d data=%02h cycle=%0d", name, beats, a_sender_data, cyc);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      prev_stall = a_sender_valid && !a_sender_ready;
      prev_data  = a_sender_data;
      if (a_receiver_valid && a_receiver_ready) begin
        w = a_receiver_data;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*8 +: 8]);
        $display("[TB] %s: accepted word %08h cycle=%0d", name, w, cyc);
        words_sent++;
      end
    end
    a_receiver_valid = 1'b0;
    check_eq({name, " completed"}, 32'((words_sent == nwords) && (exp_q.size() == 0)), 32'd1);
    check_eq({name, " beat count"}, 32'(beats), 32'(4 * nwords));
    if (!rand_ready) begin
      check_eq({name, " no bubble"}, 32'(last_cyc - first_cyc + 1), 32'(4 * nwords));
    end
  endtask

  initial begin
    reset            = 1'b1;
    a_receiver_valid = 1'b1;
    a_receiver_data  = 32'h1234_5678;
    a_sender_ready   = 1'b1;
    b_receiver_valid = 1'b0;
    b_receiver_data  = 16'h0000;
    b_sender_ready   = 1'b0;

    // Test 1: reset held 3 cycles with a valid offer pending.
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check_eq("reset rx_ready", 32'(a_receiver_ready), 32'd0);
      check_eq("reset tx_valid", 32'(a_sender_valid), 32'd0);
      check_eq("reset tx_data", 32'(a_sender_data), 32'd0);
      $display("[TB] reset cycle %0d: rx_ready=%0b tx_valid=%0b", i, a_receiver_ready, a_sender_valid);
      @(posedge clock);
    end
    @(negedge clock);
    reset            = 1'b0;
    a_receiver_valid = 1'b0;
    #1;
    check_eq("post-reset tx_valid", 32'(a_sender_valid), 32'd0);
    check_eq("post-reset rx_ready", 32'(a_receiver_ready), 32'd1);

    // Test 2: single word, LSB chunk first, ready returns on the last chunk.
    run_case("single", 1, 32'hDDCC_BBAA, 32'h0, 1'b0, 20);

    // Test 3: two back-to-back words, eight beats with no idle cycle.
    run_case("b2b", 2, 32'h0302_0100, 32'h0706_0504, 1'b0, 30);

    // Test 4: random downstream ready; order and stability under stall.
    run_case("rand", 1, 32'h4433_2211, 32'h0, 1'b1, 60);

    // Test 5: reset after AA and BB have gone out.
    @(negedge clock);
    a_receiver_valid = 1'b1;
    a_receiver_data  = 32'hDDCC_BBAA;
    a_sender_ready   = 1'b1;
    #1;
    check_eq("midreset rx_ready", 32'(a_receiver_ready), 32'd1);
    @(negedge clock);
    a_receiver_valid = 1'b0;
    #1;
    check_eq("midreset chunk0", 32'(a_sender_data), 32'hAA);
    $display("[TB] midreset: beat 0 data=%02h", a_sender_data);
    @(negedge clock);
    #1;
    check_eq("midreset chunk1", 32'(a_sender_data), 32'hBB);
    $display("[TB] midreset: beat 1 data=%02h", a_sender_data);
    @(negedge clock);
    reset          = 1'b1;
    a_sender_ready = 1'b0;
    #1;
    check_eq("midreset rx_ready in reset", 32'(a_receiver_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      check_eq("midreset tx_valid in reset", 32'(a_sender_valid), 32'd0);
      check_eq("midreset tx_data in reset", 32'(a_sender_data), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("midreset tx_valid after", 32'(a_sender_valid), 32'd0);
    run_case("after-reset", 1, 32'h0F0E_0D0C, 32'h0, 1'b0, 20);

    // Test 6: RATIO=1, 16-bit beat held under back-pressure for 5 cycles.
    @(negedge clock);
    b_receiver_valid = 1'b1;
    b_receiver_data  = 16'hBEEF;
    b_sender_ready   = 1'b0;
    #1;
    check_eq("r1 tx_valid empty", 32'(b_sender_valid), 32'd0);
    check_eq("r1 rx_ready empty", 32'(b_receiver_ready), 32'd1);
    $display("[TB] r1: word %04h offered", b_receiver_data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      b_receiver_valid = 1'b0;
      #1;
      check_eq("r1 stall valid", 32'(b_sender_valid), 32'd1);
      check_eq("r1 stall data", 32'(b_sender_data), 32'hBEEF);
      check_eq("r1 stall rx_ready", 32'(b_receiver_ready), 32'd0);
    end
    @(negedge clock);
    b_sender_ready = 1'b1;
    #1;
    check_eq("r1 send valid", 32'(b_sender_valid), 32'd1);
    check_eq("r1 send data", 32'(b_sender_data), 32'hBEEF);
    check_eq("r1 send rx_ready", 32'(b_receiver_ready), 32'd1);
    $display("[TB] r1: beat data=%04h", b_sender_data);
    @(negedge clock);
    #1;
    check_eq("r1 drained", 32'(b_sender_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
